// File: rtl/pe_job_controller.sv
// Initiator-side sequencer for one matrix-vector processing element.
// Latches a job, runs the PE enable/done protocol one to three times depending on
// mode, votes on or compares the captured results, and returns result plus status.
module pe_job_controller #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned VECTOR_SIZE    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  // Job request channel
  input  logic                                                job_valid,
  output logic                                                job_ready,
  input  logic [VECTOR_SIZE-1:0][VECTOR_SIZE-1:0][DATA_WIDTH-1:0] job_matrix,
  input  logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]              job_vector,
  input  logic [1:0]                                          job_mode,
  // PE side
  output logic                                                pe_enable,
  output logic [VECTOR_SIZE-1:0][VECTOR_SIZE-1:0][DATA_WIDTH-1:0] pe_matrix,
  output logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]              pe_vector,
  output logic [1:0]                                          pe_mode,
  input  logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]              pe_result,
  input  logic                                                pe_done,
  input  logic                                                pe_busy,
  // Response channel
  output logic                                                res_valid,
  input  logic                                                res_ready,
  output logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]              res_vector,
  output logic [2:0]                                          res_status,
  output logic [1:0]                                          res_passes,
  output logic                                                fault
);

  typedef logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] vec_t;
  typedef logic [VECTOR_SIZE-1:0][VECTOR_SIZE-1:0][DATA_WIDTH-1:0] mat_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StResp
  } state_e;

  localparam logic [1:0] ModeSingle    = 2'd0;
  localparam logic [1:0] ModeRedundant = 2'd1;
  localparam logic [1:0] ModeVote      = 2'd2;
  localparam logic [1:0] ModeIllegal   = 2'd3;

  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] StatusOk       = 3'b000;
  localparam logic [2:0] StatusMismatch = 3'b001;
  localparam logic [2:0] StatusTimeout  = 3'b010;
  localparam logic [2:0] StatusIllegal  = 3'b100;

  state_e            state_q, state_d;
  mat_t              pe_matrix_q, pe_matrix_d;
  vec_t              pe_vector_q, pe_vector_d;
  logic [1:0]        pe_mode_q, pe_mode_d;
  logic              pe_enable_q, pe_enable_d;
  logic [1:0]        pass_cnt_q, pass_cnt_d;
  logic [TimerW-1:0] timer_q, timer_d;
  vec_t              slot_q [3];
  vec_t              slot_d [3];
  logic              res_valid_q, res_valid_d;
  vec_t              res_vector_q, res_vector_d;
  logic [2:0]        res_status_q, res_status_d;
  logic [1:0]        res_passes_q, res_passes_d;
  logic              fault_q, fault_d;

  // DRAIN decision scratch
  logic              finish;
  vec_t              result_sel;
  logic [2:0]        status_sel;

  // Busy is informational only; control never depends on it.
  logic unused_pe_busy;
  assign unused_pe_busy = pe_busy;

  assign job_ready  = (state_q == StIdle) && !fault_q;
  assign pe_enable  = pe_enable_q;
  assign pe_matrix  = pe_matrix_q;
  assign pe_vector  = pe_vector_q;
  assign pe_mode    = pe_mode_q;
  assign res_valid  = res_valid_q;
  assign res_vector = res_vector_q;
  assign res_status = res_status_q;
  assign res_passes = res_passes_q;
  assign fault      = fault_q;

  // Next-state, datapath capture and pass/vote decisions.
  always_comb begin
    state_d      = state_q;
    pe_matrix_d  = pe_matrix_q;
    pe_vector_d  = pe_vector_q;
    pe_mode_d    = pe_mode_q;
    pass_cnt_d   = pass_cnt_q;
    timer_d      = timer_q;
    slot_d       = slot_q;
    res_valid_d  = res_valid_q;
    res_vector_d = res_vector_q;
    res_status_d = res_status_q;
    res_passes_d = res_passes_q;
    fault_d      = fault_q;
    finish       = 1'b0;
    result_sel   = '0;
    status_sel   = StatusOk;

    case (state_q)
      StIdle: begin
        if (job_valid && job_ready) begin
          pe_matrix_d = job_matrix;
          pe_vector_d = job_vector;
          pe_mode_d   = job_mode;
          pass_cnt_d  = 2'd0;
          timer_d     = '0;
          if (job_mode == ModeIllegal) begin
            // Rejected without touching the PE.
            state_d      = StResp;
            res_valid_d  = 1'b1;
            res_vector_d = '0;
            res_status_d = StatusIllegal;
            res_passes_d = 2'd0;
          end else begin
            state_d = StRun;
          end
        end
      end

      StRun: begin
        if (pe_done) begin
          // Done wins over a coincident timeout.
          for (int i = 0; i < 3; i++) begin
            if (pass_cnt_q == 2'(i)) slot_d[i] = pe_result;
          end
          pass_cnt_d = pass_cnt_q + 2'd1;
          state_d    = StDrain;
        end else if (timer_q == TimerMax) begin
          state_d      = StResp;
          res_valid_d  = 1'b1;
          res_vector_d = '0;
          res_status_d = StatusTimeout;
          res_passes_d = pass_cnt_q;
          fault_d      = 1'b1;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end

      StDrain: begin
        // One low-enable cycle lets the PE drop done before any further pass.
        timer_d = '0;
        case (pe_mode_q)
          ModeSingle: begin
            finish     = 1'b1;
            result_sel = slot_q[0];
          end
          ModeRedundant: begin
            if (pass_cnt_q < 2'd2) begin
              state_d = StRun;
            end else begin
              finish     = 1'b1;
              result_sel = slot_q[0];
              status_sel = (slot_q[0] != slot_q[1]) ? StatusMismatch : StatusOk;
            end
          end
          ModeVote: begin
            if (pass_cnt_q < 2'd2) begin
              state_d = StRun;
            end else if (pass_cnt_q == 2'd2) begin
              if (slot_q[0] == slot_q[1]) begin
                finish     = 1'b1;
                result_sel = slot_q[0];
              end else begin
                // Tie-breaker pass.
                state_d = StRun;
              end
            end else begin
              finish = 1'b1;
              if (slot_q[2] == slot_q[0]) begin
                result_sel = slot_q[0];
              end else if (slot_q[2] == slot_q[1]) begin
                result_sel = slot_q[1];
              end else begin
                result_sel = slot_q[2];
                status_sel = StatusMismatch;
              end
            end
          end
          default: begin
            // Illegal mode never reaches the PE; kept safe anyway.
            finish     = 1'b1;
            status_sel = StatusIllegal;
          end
        endcase
      end

      StResp: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    if (finish) begin
      state_d      = StResp;
      res_valid_d  = 1'b1;
      res_vector_d = result_sel;
      res_status_d = status_sel;
      res_passes_d = pass_cnt_q;
    end

    pe_enable_d = (state_d == StRun);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pe_matrix_q  <= '0;
      pe_vector_q  <= '0;
      pe_mode_q    <= 2'd0;
      pe_enable_q  <= 1'b0;
      pass_cnt_q   <= 2'd0;
      timer_q      <= '0;
      for (int i = 0; i < 3; i++) slot_q[i] <= '0;
      res_valid_q  <= 1'b0;
      res_vector_q <= '0;
      res_status_q <= 3'b000;
      res_passes_q <= 2'd0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pe_matrix_q  <= pe_matrix_d;
      pe_vector_q  <= pe_vector_d;
      pe_mode_q    <= pe_mode_d;
      pe_enable_q  <= pe_enable_d;
      pass_cnt_q   <= pass_cnt_d;
      timer_q      <= timer_d;
      for (int i = 0; i < 3; i++) slot_q[i] <= slot_d[i];
      res_valid_q  <= res_valid_d;
      res_vector_q <= res_vector_d;
      res_status_q <= res_status_d;
      res_passes_q <= res_passes_d;
      fault_q      <= fault_d;
    end
  end

endmodule
